// File: rtl/path_stack_pkg.sv
// Shared maze definitions: coordinate width, grid size and the path stack state encoding.
package path_stack_pkg;

    localparam int COORD_W   = 4;
    localparam int GRID_SIZE = 16;
    localparam int ENTRY_W   = 2 * COORD_W;

    typedef enum logic [1:0] {
        STACK = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// Path storage: DEPTH x ENTRY_W, one synchronous write port and two asynchronous read ports.
module stack_mem
    import path_stack_pkg::*;
#(
    parameter int DEPTH = GRID_SIZE * GRID_SIZE,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]      top_addr,
    output logic [ENTRY_W-1:0] top_data,
    input  logic [AW-1:0]      run_addr,
    output logic [ENTRY_W-1:0] run_data
);

    // Contents are deliberately never reset; only the pointers in the parent are.
    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign top_data = mem[top_addr];
    assign run_data = mem[run_addr];

endmodule

// File: rtl/path_stack.sv
// LIFO of visited maze cells with a bottom-to-top replay mode for the solved path.
module path_stack
    import path_stack_pkg::*;
#(
    parameter int DEPTH = GRID_SIZE * GRID_SIZE,
    parameter int PW    = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [COORD_W-1:0] xIn,
    input  logic [COORD_W-1:0] yIn,
    input  logic               clear,
    input  logic               run,
    input  logic               runNext,
    output logic [COORD_W-1:0] xTop,
    output logic [COORD_W-1:0] yTop,
    output logic               emptyStack,
    output logic               full,
    output logic [COORD_W-1:0] xRun,
    output logic [COORD_W-1:0] yRun,
    output logic               runValid,
    output logic               runDone,
    output logic               err
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    state_t             state;
    logic [PW-1:0]      sp;
    logic [PW-1:0]      rp;
    logic [PW-1:0]      sp_m1;
    logic               is_empty;
    logic               is_full;
    logic               in_place;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [AW-1:0]      top_addr;
    logic [AW-1:0]      run_addr;
    logic [ENTRY_W-1:0] top_data;
    logic [ENTRY_W-1:0] run_data;

    assign sp_m1    = sp - ONE;
    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH_P);
    // Push and pop together replace the top entry; on an empty stack it degrades to a push.
    assign in_place = push && pop && !is_empty;

    // run has priority over push/pop in the same STACK cycle.
    assign mem_we    = !rst && !clear && (state == STACK) && !run && push && (in_place || !is_full);
    assign mem_waddr = AW'(in_place ? sp_m1 : sp);
    assign top_addr  = AW'(sp_m1);
    // First RUN cycle loads mem[rp]; afterwards each accept loads the following entry.
    assign run_addr  = AW'(runValid ? rp + ONE : rp);

    stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    ({xIn, yIn}),
        .top_addr (top_addr),
        .top_data (top_data),
        .run_addr (run_addr),
        .run_data (run_data)
    );

    assign emptyStack = is_empty;
    assign full       = is_full;
    assign xTop       = is_empty ? '0 : top_data[ENTRY_W-1:COORD_W];
    assign yTop       = is_empty ? '0 : top_data[COORD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STACK;
            sp       <= '0;
            rp       <= '0;
            xRun     <= '0;
            yRun     <= '0;
            runValid <= 1'b0;
            runDone  <= 1'b0;
            err      <= 1'b0;
        end else if (clear) begin
            state    <= STACK;
            sp       <= '0;
            rp       <= '0;
            runValid <= 1'b0;
            runDone  <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                STACK: begin
                    if (run) begin
                        rp <= '0;
                        if (is_empty) begin
                            state    <= DONE;
                            runDone  <= 1'b1;
                            runValid <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end else if (in_place) begin
                        sp <= sp;
                    end else if (push) begin
                        if (is_full) begin
                            err <= 1'b1;
                        end else begin
                            sp <= sp + ONE;
                        end
                    end else if (pop) begin
                        if (is_empty) begin
                            err <= 1'b1;
                        end else begin
                            sp <= sp_m1;
                        end
                    end
                end
                RUN: begin
                    if (!runValid) begin
                        {xRun, yRun} <= run_data;
                        runValid     <= 1'b1;
                    end else if (runNext) begin
                        if (rp == sp_m1) begin
                            state    <= DONE;
                            runValid <= 1'b0;
                            runDone  <= 1'b1;
                        end else begin
                            rp           <= rp + ONE;
                            {xRun, yRun} <= run_data;
                        end
                    end
                end
                DONE: begin
                    runDone <= 1'b1;
                end
                default: begin
                    state <= STACK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_stack.sv
// Directed bench for path_stack: stack ops, saturation, in-place update, replay, clear and async reset.
module tb_path_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, clear, run, runNext;
    logic [3:0] xIn, yIn;
    logic [3:0] xTop, yTop, xRun, yRun;
    logic       emptyStack, full, runValid, runDone, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    path_stack #(.DEPTH(256), .PW(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .xIn        (xIn),
        .yIn        (yIn),
        .clear      (clear),
        .run        (run),
        .runNext    (runNext),
        .xTop       (xTop),
        .yTop       (yTop),
        .emptyStack (emptyStack),
        .full       (full),
        .xRun       (xRun),
        .yRun       (yRun),
        .runValid   (runValid),
        .runDone    (runDone),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [3:0] x, input logic [3:0] y);
        push = 1'b1; xIn = x; yIn = y;
        step();
        push = 1'b0;
        $display("txn push (%0d,%0d) -> top=%0d/%0d empty=%0b full=%0b err=%0b",
                 x, y, xTop, yTop, emptyStack, full, err);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
        $display("txn pop -> top=%0d/%0d empty=%0b err=%0b", xTop, yTop, emptyStack, err);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        $display("txn clear -> empty=%0b runDone=%0b err=%0b", emptyStack, runDone, err);
    endtask

    task automatic do_run();
        run = 1'b1;
        step();
        run = 1'b0;
        $display("txn run -> runValid=%0b runDone=%0b", runValid, runDone);
    endtask

    task automatic check_run(input string tag, input logic [3:0] x, input logic [3:0] y);
        step();
        $display("txn runNext -> run=%0d/%0d valid=%0b done=%0b", xRun, yRun, runValid, runDone);
        check({tag, "_x"}, xRun, x);
        check({tag, "_y"}, yRun, y);
        check({tag, "_valid"}, runValid, 1);
    endtask

    initial begin
        rst = 1'b1; push = 0; pop = 0; clear = 0; run = 0; runNext = 0; xIn = 0; yIn = 0;
        #1;
        check("rst_empty", emptyStack, 1);
        check("rst_full", full, 0);
        check("rst_xtop", xTop, 0);
        check("rst_ytop", yTop, 0);
        check("rst_err", err, 0);
        check("rst_runvalid", runValid, 0);
        check("rst_rundone", runDone, 0);
        step(); step();
        #2 rst = 1'b0;
        step();

        // Basic push / pop
        do_push(4'd1, 4'd2);
        check("push1_xtop", xTop, 1);
        check("push1_ytop", yTop, 2);
        do_push(4'd3, 4'd4);
        do_push(4'd5, 4'd6);
        check("push3_xtop", xTop, 5);
        check("push3_ytop", yTop, 6);
        check("push3_empty", emptyStack, 0);
        do_pop();
        check("pop1_xtop", xTop, 3);
        check("pop1_ytop", yTop, 4);
        do_pop();
        do_pop();
        check("pop3_empty", emptyStack, 1);
        check("pop3_err", err, 0);
        check("pop3_xtop", xTop, 0);

        // Underflow
        do_pop();
        check("under_empty", emptyStack, 1);
        check("under_err", err, 1);
        do_clear();
        check("clear_err", err, 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 256; i++) begin
            push = 1'b1; xIn = 4'(i >> 4); yIn = 4'(i);
            step();
            if (i == 254) check("fill255_full", full, 0);
        end
        push = 1'b0;
        $display("txn fill 256 -> top=%0d/%0d full=%0b err=%0b", xTop, yTop, full, err);
        check("fill_full", full, 1);
        check("fill_err", err, 0);
        check("fill_xtop", xTop, 15);
        check("fill_ytop", yTop, 15);
        do_push(4'd7, 4'd7);
        check("over_full", full, 1);
        check("over_err", err, 1);
        check("over_xtop", xTop, 15);
        check("over_ytop", yTop, 15);
        do_pop();
        check("over_pop_full", full, 0);
        check("over_pop_xtop", xTop, 15);
        check("over_pop_ytop", yTop, 14);

        // In-place replace
        do_clear();
        do_push(4'd1, 4'd1);
        push = 1'b1; pop = 1'b1; xIn = 4'd9; yIn = 4'd9;
        step();
        push = 1'b0; pop = 1'b0;
        $display("txn push+pop (9,9) -> top=%0d/%0d", xTop, yTop);
        check("inplace_xtop", xTop, 9);
        check("inplace_ytop", yTop, 9);
        do_pop();
        check("inplace_sp1", emptyStack, 1);
        check("inplace_err", err, 0);
        push = 1'b1; pop = 1'b1; xIn = 4'd2; yIn = 4'd3;
        step();
        push = 1'b0; pop = 1'b0;
        $display("txn push+pop empty (2,3) -> top=%0d/%0d err=%0b", xTop, yTop, err);
        check("pp_empty_xtop", xTop, 2);
        check("pp_empty_ytop", yTop, 3);
        check("pp_empty_err", err, 0);

        // Replay
        do_clear();
        do_push(4'd0, 4'd0);
        do_push(4'd0, 4'd1);
        do_push(4'd1, 4'd1);
        do_run();
        check("run_wait_valid", runValid, 0);
        runNext = 1'b1; push = 1'b1; xIn = 4'd8; yIn = 4'd8;
        check_run("run0", 4'd0, 4'd0);
        push = 1'b0;
        check_run("run1", 4'd0, 4'd1);
        check_run("run2", 4'd1, 4'd1);
        step();
        runNext = 1'b0;
        check("run_done", runDone, 1);
        check("run_done_valid", runValid, 0);
        check("run_push_ign_x", xTop, 1);
        check("run_push_ign_y", yTop, 1);
        do_pop();
        check("done_pop_ign", emptyStack, 0);
        check("done_hold", runDone, 1);

        // Run on empty, then clear
        do_clear();
        do_run();
        check("erun_done", runDone, 1);
        check("erun_valid", runValid, 0);
        do_clear();
        check("erun_clear_done", runDone, 0);
        do_push(4'd4, 4'd5);
        check("erun_stack_x", xTop, 4);
        check("erun_stack_y", yTop, 5);

        // Async reset mid-replay with rp=1
        do_clear();
        do_push(4'd2, 4'd2);
        do_push(4'd3, 4'd3);
        do_push(4'd4, 4'd4);
        do_run();
        runNext = 1'b1;
        check_run("arst_run0", 4'd2, 4'd2);
        check_run("arst_run1", 4'd3, 4'd3);
        runNext = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("txn async rst -> run=%0d/%0d valid=%0b empty=%0b", xRun, yRun, runValid, emptyStack);
        check("arst_valid", runValid, 0);
        check("arst_xrun", xRun, 0);
        check("arst_yrun", yRun, 0);
        check("arst_empty", emptyStack, 1);
        check("arst_xtop", xTop, 0);
        check("arst_done", runDone, 0);
        #3 rst = 1'b0;
        step();
        do_push(4'd6, 4'd7);
        do_push(4'd8, 4'd9);
        do_run();
        runNext = 1'b1;
        check_run("post_run0", 4'd6, 4'd7);
        check_run("post_run1", 4'd8, 4'd9);
        step();
        runNext = 1'b0;
        check("post_done", runDone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
